// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one ce-gated fixed-latency multiplier among N_REQ requesters.
// Ports: clk, rst (sync, active-high); in_a/in_b/in_valid/in_ready (operand side);
//   out_data/out_valid/out_ready (result side); mul_a/mul_b/mul_ce/mul_p (multiplier);
//   optional stat_grants/stat_stalls when MUL_SHARE_STATS_EN is defined.
module mul_share_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_b,
  input  logic [N_REQ-1:0]            in_valid,
  output logic [N_REQ-1:0]            in_ready,
  output logic [N_REQ*DATA_WIDTH-1:0] out_data,
  output logic [N_REQ-1:0]            out_valid,
  input  logic [N_REQ-1:0]            out_ready,
  output logic [DATA_WIDTH-1:0]       mul_a,
  output logic [DATA_WIDTH-1:0]       mul_b,
  output logic                        mul_ce,
  input  logic [DATA_WIDTH-1:0]       mul_p
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         stat_grants,
  output logic [15:0]                 stat_stalls
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [LATENCY-1:0] vld_q;
  logic [IW-1:0]      id_q [LATENCY];
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_id;
  logic [IW-1:0]      rr_nxt;
  logic               found;
  logic               fire;
  logic               tail_vld;
  logic [IW-1:0]      tail_id;
  logic               stall;

  assign tail_vld = vld_q[LATENCY-1];
  assign tail_id  = id_q[LATENCY-1];
  assign stall    = tail_vld & ~out_ready[tail_id];
  assign mul_ce   = ~stall & ~rst;

  // Scan from rr_ptr upward, wrapping; gnt_id falls back to rr_ptr
  // so idle operands still come from a defined slice.
  always_comb begin
    found  = 1'b0;
    gnt_id = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && in_valid[j]) begin
        found  = 1'b1;
        gnt_id = IW'(j);
      end
    end
  end

  assign fire   = found & mul_ce;
  assign rr_nxt = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    in_ready = '0;
    if (fire) in_ready[gnt_id] = 1'b1;
  end

  assign mul_a = in_a[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  assign mul_b = in_b[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      rr_ptr <= '0;
    end else if (mul_ce) begin
      for (int i = LATENCY - 1; i > 0; i--)
        vld_q[i] <= vld_q[i-1];
      vld_q[0] <= fire;
      if (fire) rr_ptr <= rr_nxt;
    end
  end

  // Ids are masked by vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      for (int i = LATENCY - 1; i > 0; i--)
        id_q[i] <= id_q[i-1];
      id_q[0] <= gnt_id;
    end
  end

  always_comb begin
    out_valid = '0;
    if (tail_vld && !rst) out_valid[tail_id] = 1'b1;
  end

  assign out_data = {N_REQ{mul_p}};

`ifdef MUL_SHARE_STATS_EN
  logic [15:0] gcnt [N_REQ];
  logic [15:0] scnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) gcnt[i] <= '0;
      scnt <= '0;
    end else begin
      if (fire && gcnt[gnt_id] != 16'hFFFF)
        gcnt[gnt_id] <= gcnt[gnt_id] + 16'd1;
      if (stall && scnt != 16'hFFFF)
        scnt <= scnt + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = gcnt[g];
  end
  assign stat_stalls = scnt;
`endif

endmodule
